// File: rtl/cache_control_pkg.sv
// cache_types: shared FSM state enum, datapath mux encodings and default way count for the L1 cache controller
package cache_types;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  localparam logic SRC_CPU = 1'b0;
  localparam logic SRC_PMEM = 1'b1;
  localparam logic ADDR_CPU = 1'b0;
  localparam logic ADDR_VICTIM = 1'b1;
  localparam int NUM_WAYS_DEF = 2;
endpackage

// File: rtl/cache_control_hit_encoder.sv
// hit_encoder: one-hot hit vector (hit) to way index (idx, lowest set bit wins) plus any_hit
module hit_encoder #(
  parameter int n = 2,
  parameter int s = $clog2(n)
) (
  input  logic [n-1:0] hit,
  output logic [s-1:0] idx,
  output logic         any_hit
);
  always_comb begin
    idx = '0;
    for (int i = n - 1; i >= 0; i--) idx = hit[i] ? s'(i) : idx;
  end
  assign any_hit = |hit;
endmodule

// File: rtl/cache_control.sv
// cache_control: write-back N-way L1 FSM (IDLE/WRITEBACK/ALLOCATE); ports: clk, rst, CPU mem_read/mem_write/mem_resp, datapath hit/dirty/victim, array strobes way_sel/load_*/data_src/dirty_in/lru_way, pmem_read/pmem_write/pmem_resp/addr_sel; CACHE_PERF_CNT_EN adds saturating hit_count/miss_count
module cache_control
  import cache_types::*;
#(
  parameter int num_ways = NUM_WAYS_DEF,
  parameter int s_way = $clog2(num_ways)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic [num_ways-1:0] hit,
  input  logic [num_ways-1:0] dirty,
  input  logic [s_way-1:0]    victim,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  output logic [s_way-1:0]    way_sel,
  output logic                load_data,
  output logic                data_src,
  output logic                load_tag,
  output logic                load_dirty,
  output logic                dirty_in,
  output logic                load_lru,
  output logic [s_way-1:0]    lru_way,
  output logic                addr_sel
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);
  state_t state, next;
  logic [s_way-1:0] victim_q, hit_idx;
  logic any_hit;
  logic req;
  assign req = mem_read | mem_write;
  hit_encoder #(.n(num_ways), .s(s_way)) u_enc (.hit(hit), .idx(hit_idx), .any_hit(any_hit));
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : next;
    victim_q <= (state == IDLE && req && !any_hit) ? victim : victim_q;
  end
  always_comb begin
    next = state;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    way_sel = '0;
    load_data = 1'b0;
    data_src = SRC_CPU;
    load_tag = 1'b0;
    load_dirty = 1'b0;
    dirty_in = 1'b0;
    load_lru = 1'b0;
    lru_way = '0;
    addr_sel = ADDR_CPU;
    if (!rst)
      case (state)
        IDLE: if (req) begin
          if (any_hit) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            lru_way = hit_idx;
            way_sel = mem_write ? hit_idx : '0;
            load_data = mem_write;
            load_dirty = mem_write;
            dirty_in = mem_write;
          end else begin
            way_sel = victim;
            next = dirty[victim] ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          addr_sel = ADDR_VICTIM;
          way_sel = victim_q;
          next = pmem_resp ? ALLOCATE : WRITEBACK;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          way_sel = victim_q;
          load_data = pmem_resp;
          data_src = pmem_resp ? SRC_PMEM : SRC_CPU;
          load_tag = pmem_resp;
          load_dirty = pmem_resp;
          next = pmem_resp ? IDLE : ALLOCATE;
        end
        default: next = IDLE;
      endcase
  end
`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    hit_count <= rst ? '0 : hit_count + 32'(mem_resp && !(&hit_count));
    miss_count <= rst ? '0 : miss_count + 32'(state == IDLE && next != IDLE && !(&miss_count));
  end
`endif
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: scoreboard bench for cache_control; expected output vectors queued per driven cycle, compared at the following negedge
module tb_cache_control;
  logic clk, rst, mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [1:0] hit, dirty;
  logic victim, way_sel, load_data, data_src, load_tag, load_dirty, dirty_in, load_lru, lru_way, addr_sel;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif
  int checks = 0, passed = 0;
  logic [11:0] exp_q[$];
  string tag_q[$];
  cache_control #(.num_ways(2)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .dirty(dirty), .victim(victim), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .way_sel(way_sel), .load_data(load_data), .data_src(data_src),
    .load_tag(load_tag), .load_dirty(load_dirty), .dirty_in(dirty_in), .load_lru(load_lru),
    .lru_way(lru_way), .addr_sel(addr_sel)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [11:0] ev(input logic resp, pr, pw, ws, ld, ds, lt, ldy, din, llru, lw, as);
    return {resp, pr, pw, ws, ld, ds, lt, ldy, din, llru, lw, as};
  endfunction
  always @(negedge clk)
    if (exp_q.size() != 0)
      chk(tag_q.pop_front(), 32'({mem_resp, pmem_read, pmem_write, way_sel, load_data, data_src,
                                  load_tag, load_dirty, dirty_in, load_lru, lru_way, addr_sel}),
          32'(exp_q.pop_front()));
  task automatic step(input string tag, input logic r, w, p, input logic [1:0] h, d, input logic v,
                      input logic [11:0] e);
    mem_read = r;
    mem_write = w;
    pmem_resp = p;
    hit = h;
    dirty = d;
    victim = v;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    {mem_read, mem_write, pmem_resp, hit, dirty, victim} = '0;
    @(posedge clk);
    #1;
    step("reset_gate", 1, 0, 0, 2'b10, 2'b00, 0, '0);
`ifdef CACHE_PERF_CNT_EN
    chk("reset_hit_count", hit_count, 0);
    chk("reset_miss_count", miss_count, 0);
`endif
    rst = 1'b0;
    step("idle", 0, 0, 0, 2'b00, 2'b00, 0, '0);
    step("rd_hit_w1", 1, 0, 0, 2'b10, 2'b00, 0, ev(1,0,0,0,0,0,0,0,0,1,1,0));
    step("wr_hit_w0", 0, 1, 0, 2'b01, 2'b00, 0, ev(1,0,0,0,1,0,0,1,1,1,0,0));
    step("wr_hit_w1", 0, 1, 0, 2'b10, 2'b00, 0, ev(1,0,0,1,1,0,0,1,1,1,1,0));
    step("multi_hit", 1, 0, 0, 2'b11, 2'b00, 0, ev(1,0,0,0,0,0,0,0,0,1,0,0));
    step("clean_miss", 1, 0, 0, 2'b00, 2'b00, 1, ev(0,0,0,1,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      step("alloc_wait", 1, 0, 0, 2'b00, 2'b00, i[0], ev(0,1,0,1,0,0,0,0,0,0,0,0));
    step("alloc_fill", 1, 0, 1, 2'b00, 2'b00, 0, ev(0,1,0,1,1,1,1,1,0,0,0,0));
    step("miss_rehit", 1, 0, 0, 2'b10, 2'b00, 0, ev(1,0,0,0,0,0,0,0,0,1,1,0));
    step("dirty_miss", 0, 1, 0, 2'b00, 2'b01, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 2; i++)
      step("wb_wait", 0, 1, 0, 2'b00, 2'b01, 1, ev(0,0,1,0,0,0,0,0,0,0,0,1));
    step("wb_done", 0, 1, 1, 2'b00, 2'b01, 1, ev(0,0,1,0,0,0,0,0,0,0,0,1));
    step("alloc2_wait", 0, 1, 0, 2'b00, 2'b01, 1, ev(0,1,0,0,0,0,0,0,0,0,0,0));
    step("alloc2_fill", 0, 1, 1, 2'b00, 2'b01, 1, ev(0,1,0,0,1,1,1,1,0,0,0,0));
    step("dirty_rehit", 0, 1, 0, 2'b01, 2'b01, 1, ev(1,0,0,0,1,0,0,1,1,1,0,0));
`ifdef CACHE_PERF_CNT_EN
    chk("hit_count", hit_count, 6);
    chk("miss_count", miss_count, 2);
`endif
    step("idle_presp", 0, 0, 1, 2'b00, 2'b00, 0, '0);
    step("idle_after_presp", 0, 0, 0, 2'b00, 2'b00, 0, '0);
    step("abort_miss", 1, 0, 0, 2'b00, 2'b00, 1, ev(0,0,0,1,0,0,0,0,0,0,0,0));
    step("abort_wait", 0, 0, 0, 2'b00, 2'b00, 0, ev(0,1,0,1,0,0,0,0,0,0,0,0));
    step("abort_fill", 0, 0, 1, 2'b00, 2'b00, 0, ev(0,1,0,1,1,1,1,1,0,0,0,0));
    step("abort_idle", 0, 0, 0, 2'b00, 2'b00, 0, '0);
    step("rstwb_miss", 0, 1, 0, 2'b00, 2'b10, 1, ev(0,0,0,1,0,0,0,0,0,0,0,0));
    step("rstwb_wb", 0, 1, 0, 2'b00, 2'b10, 1, ev(0,0,1,1,0,0,0,0,0,0,0,1));
    rst = 1'b1;
    step("rstwb_rst", 0, 1, 0, 2'b00, 2'b10, 1, '0);
    rst = 1'b0;
    step("rstwb_idle", 0, 0, 0, 2'b00, 2'b10, 1, '0);
`ifdef CACHE_PERF_CNT_EN
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
